bus_decoder: RTL and testbench
==============================

Name: bus_decoder

Overview:
- Parametrised 68000 bus-cycle controller: address decode, byte-lane chip selects, per-region wait-state DTACK generation, bus-error timeout and boot ROM overlay.
- Sits between the CPU bus pins (already inverted to active-high at top level) and SRAM/PROM chip enables.
- Replaces the tied-off chip-select, OE and BERR logic and the fixed-latency DTACK path.

Parameters:
ADDR_WIDTH, 24, CPU address width; bit 0 is ignored.
ROM_BASE, 24'hFC0000, PROM region base; must be aligned to 2^ROM_SIZE_LOG2.
ROM_SIZE_LOG2, 18, PROM region size is 2^ROM_SIZE_LOG2 bytes.
RAM_BASE, 24'h000000, SRAM region base; must be aligned to 2^RAM_SIZE_LOG2.
RAM_SIZE_LOG2, 20, SRAM region size is 2^RAM_SIZE_LOG2 bytes.
ROM_WAIT, 2, extra wait cycles before DTACK for PROM; range 0..15.
RAM_WAIT, 0, extra wait cycles before DTACK for SRAM; range 0..15.
BERR_TIMEOUT, 16, cycles before BERR on an unmapped access; range 1..255.
BOOT_CYCLES, 4, completed bus cycles served by the overlay after reset.
ROM_WP, 1, when 1 a write to PROM raises BERR.

Ports:
CPUCLK_IN  in  1  bus clock; the only clock.
RESET_n_IN  in  1  synchronous active-low reset.
AS_IN  in  1  address strobe, active-high, synchronous to CPUCLK_IN.
UDS_IN  in  1  upper data strobe (D15..D8), active-high.
LDS_IN  in  1  lower data strobe (D7..D0), active-high.
RW_IN  in  1  1 = read, 0 = write.
ADDR_IN  in  ADDR_WIDTH  CPU address.
DTACK  out  1  data acknowledge, active-high.
BERR  out  1  bus error, active-high.
SRAMCS0  out  1  SRAM upper-byte select.
SRAMCS1  out  1  SRAM lower-byte select.
PROMCS0  out  1  PROM upper-byte select.
PROMCS1  out  1  PROM lower-byte select.
OE  out  1  memory output enable (read cycles).
OVERLAY  out  1  boot overlay active.
BUSY  out  1  state is not IDLE.

Behaviour:
- Reset (RESET_n_IN=0 at a clock edge):
  - state to IDLE;
  - DTACK, BERR, all CS, OE and BUSY to 0;
  - OVERLAY to 1; overlay cycle counter to 0.
  - Reset mid-cycle aborts the cycle with no DTACK.
- States: IDLE, WAIT, ACK, ERR.
- IDLE:
  - Start condition: AS_IN & (UDS_IN | LDS_IN) at edge n.
  - Decode and register the region from ADDR_IN at edge n.
  - From edge n+1, with region = ROM: PROMCS0=UDS_IN, PROMCS1=LDS_IN.
  - From edge n+1, with region = RAM: SRAMCS0=UDS_IN, SRAMCS1=LDS_IN.
  - OE = RW_IN & (any CS).
- Decode priority:
  - OVERLAY=1 and RW_IN=1: ROM, at offset ADDR_IN mod 2^ROM_SIZE_LOG2.
  - Otherwise, address in ROM window: ROM.
  - Otherwise, address in RAM window: RAM.
  - Otherwise: unmapped.
- Mapped start: load wait counter with ROM_WAIT or RAM_WAIT.
  - Counter is 0: go to ACK; DTACK is high from edge n+1.
  - Otherwise: go to WAIT.
- WAIT: decrement each cycle; on reaching 0 go to ACK.
  - DTACK first asserts at edge n+1+WAIT.
- Unmapped start, or ROM write with ROM_WP=1:
  - No CS asserted.
  - Count BERR_TIMEOUT cycles, then ERR: BERR=1.
  - ROM write protection uses a timeout of 1 cycle.
- ACK/ERR: hold DTACK or BERR, CS and OE until AS_IN=0.
  - On the edge sampling AS_IN=0, go to IDLE; all outputs are 0 one cycle later.
- Abort: AS_IN=0 in WAIT or during the timeout count.
  - Go to IDLE; no DTACK or BERR is ever asserted for that cycle.
- CS lanes track UDS_IN/LDS_IN each cycle while the cycle is active (read-modify-write and strobe skew).
- DTACK and BERR are never asserted together.
- Back-to-back cycles: a new start is recognised in IDLE only. The minimum gap is one IDLE cycle.
- Overlay:
  - Each cycle that completes through ACK while OVERLAY=1 increments the overlay cycle counter.
  - OVERLAY clears after the BOOT_CYCLES-th completion.
  - OVERLAY also clears on the first write cycle start.
  - Aborted and BERR cycles do not count.
  - OVERLAY returns to 1 only on reset.
- Region windows are compared on address bits [ADDR_WIDTH-1:SIZE_LOG2]. A region size covering the whole address space matches every address.
- Overlapping windows: ROM wins.

Test Plan:
- Reset, then read 0x000000 and 0x000002 with UDS=LDS=1:
  - PROMCS0=PROMCS1=OE=1; DTACK at edge n+3 (ROM_WAIT=2).
  - After the 4th completed read, OVERLAY=0 and a read of 0x000000 asserts SRAMCS0/1 with DTACK at n+1.
- After overlay: write 0x001235 with LDS only:
  - SRAMCS1=1, SRAMCS0=0, OE=0; DTACK at n+1.
  - Hold AS 5 extra cycles: DTACK stays 1; it drops one cycle after AS_IN=0.
- Read 0x800000 (unmapped): no CS; BERR=1 exactly 16 cycles after the start edge; DTACK never asserts.
- Write 0xFC0010 with ROM_WP=1: BERR after 1 cycle; PROMCS0/1 stay 0.
- Read ROM and drop AS after 1 cycle in WAIT: return to IDLE, no DTACK; the overlay counter is unchanged.
- Assert RESET_n_IN=0 during ACK: the next edge has all outputs 0 and OVERLAY=1; the next read of 0x000000 selects PROM.

Source files
------------

// File: rtl/bus_decoder_if.sv
// 68000 bus pins (already active-high) between the CPU side and the bus-cycle controller.
interface bus_decoder_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  AS_IN;
  logic                  UDS_IN;
  logic                  LDS_IN;
  logic                  RW_IN;
  logic [ADDR_WIDTH-1:0] ADDR_IN;
  logic                  DTACK;
  logic                  BERR;
  logic                  SRAMCS0;
  logic                  SRAMCS1;
  logic                  PROMCS0;
  logic                  PROMCS1;
  logic                  OE;
  logic                  OVERLAY;
  logic                  BUSY;

  modport master (
    output AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN,
    input  DTACK, BERR, SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, OVERLAY, BUSY
  );

  modport slave (
    input  AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN,
    output DTACK, BERR, SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, OVERLAY, BUSY
  );
endinterface

// File: rtl/bus_decoder.sv
// 68000 bus-cycle controller: region decode, byte-lane chip selects, wait-state DTACK,
// unmapped/write-protect BERR timeout and a boot overlay mapping all reads to PROM.
module bus_decoder #(
  parameter int                    ADDR_WIDTH    = 24,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE      = 24'hFC0000,
  parameter int                    ROM_SIZE_LOG2 = 18,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE      = 24'h000000,
  parameter int                    RAM_SIZE_LOG2 = 20,
  parameter int                    ROM_WAIT      = 2,
  parameter int                    RAM_WAIT      = 0,
  parameter int                    BERR_TIMEOUT  = 16,
  parameter int                    BOOT_CYCLES   = 4,
  parameter int                    ROM_WP        = 1
) (
  input  logic         CPUCLK_IN,
  input  logic         RESET_n_IN,
  bus_decoder_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_e;
  typedef enum logic [1:0] {RG_NONE, RG_ROM, RG_RAM} region_e;

  // A window as large as the address space has an all-zero mask and matches everything.
  localparam logic [ADDR_WIDTH-1:0] ROM_MASK = (ROM_SIZE_LOG2 >= ADDR_WIDTH) ?
                                               {ADDR_WIDTH{1'b0}} : ({ADDR_WIDTH{1'b1}} << ROM_SIZE_LOG2);
  localparam logic [ADDR_WIDTH-1:0] RAM_MASK = (RAM_SIZE_LOG2 >= ADDR_WIDTH) ?
                                               {ADDR_WIDTH{1'b0}} : ({ADDR_WIDTH{1'b1}} << RAM_SIZE_LOG2);
  localparam logic [7:0]  ROM_WAIT_C = 8'(ROM_WAIT);
  localparam logic [7:0]  RAM_WAIT_C = 8'(RAM_WAIT);
  localparam logic [7:0]  BERR_CNT_C = 8'(BERR_TIMEOUT - 1);
  localparam logic [15:0] BOOT_LIM   = 16'(BOOT_CYCLES);

  function automatic region_e decode(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic rw, input logic ovl);
    region_e r;
    if (ovl && rw) begin
      r = RG_ROM;
    end else if (((addr ^ ROM_BASE) & ROM_MASK) == {ADDR_WIDTH{1'b0}}) begin
      r = RG_ROM;
    end else if (((addr ^ RAM_BASE) & RAM_MASK) == {ADDR_WIDTH{1'b0}}) begin
      r = RG_RAM;
    end else begin
      r = RG_NONE;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  region_e     dec_region_s;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] ovl_cnt_q, ovl_cnt_d;
  logic        ovl_q, ovl_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;
  logic [1:0]  prom_cs_q, prom_cs_d;
  logic [1:0]  sram_cs_q, sram_cs_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        start_s;
  logic        active_s;

  assign start_s      = bus.AS_IN & (bus.UDS_IN | bus.LDS_IN);
  assign dec_region_s = decode(bus.ADDR_IN, bus.RW_IN, ovl_q);

  // Next-state, counters and registered-output precompute.
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    cnt_d     = cnt_q;
    ovl_d     = ovl_q;
    ovl_cnt_d = ovl_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_WAIT;
          if (!bus.RW_IN) begin
            ovl_d = 1'b0;
          end else begin
            ovl_d = ovl_q;
          end
          // Write-protected PROM is handled as an error cycle with a one-cycle timeout.
          if (dec_region_s == RG_ROM && !bus.RW_IN && ROM_WP != 0) begin
            region_d = RG_NONE;
            cnt_d    = 8'd0;
          end else if (dec_region_s == RG_ROM) begin
            region_d = RG_ROM;
            cnt_d    = ROM_WAIT_C;
          end else if (dec_region_s == RG_RAM) begin
            region_d = RG_RAM;
            cnt_d    = RAM_WAIT_C;
          end else begin
            region_d = RG_NONE;
            cnt_d    = BERR_CNT_C;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.AS_IN) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = (region_q == RG_NONE) ? ST_ERR : ST_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        if (!bus.AS_IN) begin
          state_d = ST_IDLE;
          if (ovl_q) begin
            ovl_cnt_d = ovl_cnt_q + 16'd1;
            ovl_d     = ((ovl_cnt_q + 16'd1) == BOOT_LIM) ? 1'b0 : 1'b1;
          end else begin
            ovl_cnt_d = ovl_cnt_q;
          end
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ERR: begin
        if (!bus.AS_IN) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Lanes follow the live strobes on every edge after the start edge.
    active_s  = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    prom_cs_d = (active_s && region_q == RG_ROM) ? {bus.UDS_IN, bus.LDS_IN} : 2'b00;
    sram_cs_d = (active_s && region_q == RG_RAM) ? {bus.UDS_IN, bus.LDS_IN} : 2'b00;
    oe_d      = bus.RW_IN & ((|prom_cs_d) | (|sram_cs_d));
    dtack_d   = (state_d == ST_ACK);
    berr_d    = (state_d == ST_ERR);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CPUCLK_IN) begin
    if (!RESET_n_IN) begin
      state_q   <= ST_IDLE;
      region_q  <= RG_NONE;
      cnt_q     <= 8'd0;
      ovl_q     <= 1'b1;
      ovl_cnt_q <= 16'd0;
      dtack_q   <= 1'b0;
      berr_q    <= 1'b0;
      prom_cs_q <= 2'b00;
      sram_cs_q <= 2'b00;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      cnt_q     <= cnt_d;
      ovl_q     <= ovl_d;
      ovl_cnt_q <= ovl_cnt_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
      prom_cs_q <= prom_cs_d;
      sram_cs_q <= sram_cs_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.DTACK   = dtack_q;
  assign bus.BERR    = berr_q;
  assign bus.PROMCS0 = prom_cs_q[1];
  assign bus.PROMCS1 = prom_cs_q[0];
  assign bus.SRAMCS0 = sram_cs_q[1];
  assign bus.SRAMCS1 = sram_cs_q[0];
  assign bus.OE      = oe_q;
  assign bus.OVERLAY = ovl_q;
  assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: directed table of bus cycles, hand sequences for abort,
// strobe tracking and reset-in-ACK, then random cycles against a transaction-level model.
module tb_bus_decoder;

  localparam int K_NONE = 0;
  localparam int K_ROM  = 1;
  localparam int K_RAM  = 2;
  localparam int K_WP   = 3;

  localparam int M_ROM_WAIT = 2;
  localparam int M_RAM_WAIT = 0;
  localparam int M_TIMEOUT  = 16;
  localparam int M_BOOT     = 4;

  typedef struct {
    logic [23:0] addr;
    logic        rw;
    logic [1:0]  lanes;
    int          as_len;
    int          kind;
    int          lat;
    logic        o_start;
    logic        o_end;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic m_ovl;
  int   m_boot;
  vec_t tbl [14];

  bus_decoder_if #(.ADDR_WIDTH(24)) bif ();

  bus_decoder dut (
    .CPUCLK_IN  (clk),
    .RESET_n_IN (rst_n),
    .bus        (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic [8:0] exp);
    logic [8:0] act;
    act = {bif.BUSY, bif.DTACK, bif.BERR, bif.PROMCS0, bif.PROMCS1,
           bif.SRAMCS0, bif.SRAMCS1, bif.OE, bif.OVERLAY};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc%0d: got %b want %b (busy dtack berr pcs0 pcs1 scs0 scs1 oe ovl)",
               tag, k, act, exp);
    end
  endtask

  task automatic idle_pins();
    bif.AS_IN  = 1'b0;
    bif.UDS_IN = 1'b0;
    bif.LDS_IN = 1'b0;
    bif.RW_IN  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_pins();
    repeat (2) @(negedge clk);
    check("reset", 0, 9'b000000001);
    rst_n  = 1'b1;
    m_ovl  = 1'b1;
    m_boot = 0;
  endtask

  // Drives one cycle from a negedge; AS is sampled high on as_len edges, then low.
  task automatic bus_cycle(input string tag, input logic [23:0] addr, input logic rw,
                           input logic [1:0] lanes, input int as_len, input int kind,
                           input int lat, input logic o_start, input logic o_end,
                           input int chg_k, input logic [1:0] lanes2);
    logic [1:0] cur;
    logic [8:0] exp;
    logic       live;
    logic       mapped;
    cur         = lanes;
    mapped      = (kind == K_ROM) || (kind == K_RAM);
    bif.ADDR_IN = addr;
    bif.RW_IN   = rw;
    bif.UDS_IN  = lanes[1];
    bif.LDS_IN  = lanes[0];
    bif.AS_IN   = 1'b1;
    for (int k = 0; k <= as_len; k++) begin
      @(negedge clk);
      live   = (k < as_len);
      exp    = 9'b0;
      exp[8] = live;
      exp[7] = live && mapped && (k >= lat);
      exp[6] = live && !mapped && (k >= lat);
      if (live && k >= 1 && kind == K_ROM) exp[5:4] = cur;
      if (live && k >= 1 && kind == K_RAM) exp[3:2] = cur;
      exp[1] = rw && (|exp[5:2]);
      exp[0] = live ? o_start : o_end;
      check(tag, k, exp);
      if (k == chg_k) begin
        cur        = lanes2;
        bif.UDS_IN = lanes2[1];
        bif.LDS_IN = lanes2[0];
      end
      if (k == as_len - 1) idle_pins();
    end
  endtask

  function automatic int classify(input logic [23:0] a, input logic rw, input logic ovl);
    int unsigned ai;
    ai = 32'(a);
    if (ovl && rw) return K_ROM;
    if ((ai >> 18) == (32'hFC0000 >> 18)) return rw ? K_ROM : K_WP;
    if ((ai >> 20) == 32'd0) return K_RAM;
    return K_NONE;
  endfunction

  function automatic int latency(input int kind);
    if (kind == K_ROM) return M_ROM_WAIT + 1;
    if (kind == K_RAM) return M_RAM_WAIT + 1;
    if (kind == K_WP) return 1;
    return M_TIMEOUT;
  endfunction

  initial begin
    logic [23:0] addr;
    logic        rw;
    logic [1:0]  lanes;
    logic [1:0]  lanes2;
    int          as_len;
    int          kind;
    int          lat;
    int          chg_k;
    logic        o_start;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bif.ADDR_IN = 24'h000000;
    idle_pins();

    tbl[0]  = '{24'h000000, 1'b1, 2'b11,  5, K_ROM,   3, 1'b1, 1'b1};
    tbl[1]  = '{24'h000002, 1'b1, 2'b11,  5, K_ROM,   3, 1'b1, 1'b1};
    tbl[2]  = '{24'h000004, 1'b1, 2'b10,  4, K_ROM,   3, 1'b1, 1'b1};
    tbl[3]  = '{24'h000006, 1'b1, 2'b01,  4, K_ROM,   3, 1'b1, 1'b0};
    tbl[4]  = '{24'h000000, 1'b1, 2'b11,  3, K_RAM,   1, 1'b0, 1'b0};
    tbl[5]  = '{24'h001235, 1'b0, 2'b01,  7, K_RAM,   1, 1'b0, 1'b0};
    tbl[6]  = '{24'h800000, 1'b1, 2'b11, 18, K_NONE, 16, 1'b0, 1'b0};
    tbl[7]  = '{24'hFC0010, 1'b0, 2'b11,  3, K_WP,    1, 1'b0, 1'b0};
    tbl[8]  = '{24'hFC0000, 1'b1, 2'b11,  4, K_ROM,   3, 1'b0, 1'b0};
    tbl[9]  = '{24'hFFFFFE, 1'b1, 2'b10,  4, K_ROM,   3, 1'b0, 1'b0};
    tbl[10] = '{24'h0FFFFE, 1'b1, 2'b01,  2, K_RAM,   1, 1'b0, 1'b0};
    tbl[11] = '{24'h100000, 1'b1, 2'b11, 17, K_NONE, 16, 1'b0, 1'b0};
    tbl[12] = '{24'hFBFFFE, 1'b1, 2'b11, 16, K_NONE, 16, 1'b0, 1'b0};
    tbl[13] = '{24'hFC0100, 1'b1, 2'b11,  2, K_ROM,   3, 1'b0, 1'b0};

    do_reset();

    // An aborted overlay read must not advance the boot count the table relies on.
    bus_cycle("ovl_abort", 24'h000010, 1'b1, 2'b11, 2, K_ROM, 3, 1'b1, 1'b1, -1, 2'b00);

    for (int i = 0; i < 14; i++) begin
      bus_cycle($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].rw, tbl[i].lanes, tbl[i].as_len,
                tbl[i].kind, tbl[i].lat, tbl[i].o_start, tbl[i].o_end, -1, 2'b00);
    end

    bus_cycle("rmw_lanes", 24'h000100, 1'b1, 2'b11, 5, K_RAM, 1, 1'b0, 1'b0, 2, 2'b10);

    // Reset while in ACK: everything clears, overlay returns, next read goes to PROM.
    bif.ADDR_IN = 24'h000000;
    bif.RW_IN   = 1'b1;
    bif.UDS_IN  = 1'b1;
    bif.LDS_IN  = 1'b1;
    bif.AS_IN   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_ack", 1, 9'b110001110);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ack", 2, 9'b000000001);
    rst_n = 1'b1;
    idle_pins();
    bus_cycle("post_rst", 24'h000000, 1'b1, 2'b11, 4, K_ROM, 3, 1'b1, 1'b1, -1, 2'b00);

    do_reset();
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = 24'hFC0000 | 24'($urandom_range(0, 32'h3FFFF));
        1:       addr = 24'($urandom_range(0, 32'hFFFFF));
        2:       addr = 24'($urandom_range(32'h100000, 32'hFBFFFF));
        default: addr = 24'($urandom);
      endcase
      rw     = ($urandom_range(0, 4) != 0);
      lanes  = 2'($urandom_range(1, 3));
      lanes2 = 2'($urandom_range(1, 3));
      as_len = $urandom_range(1, 20);
      chg_k  = (as_len >= 3) ? $urandom_range(1, as_len - 2) : -1;
      kind   = classify(addr, rw, m_ovl);
      lat    = latency(kind);
      if (!rw) m_ovl = 1'b0;
      o_start = m_ovl;
      if ((kind == K_ROM || kind == K_RAM) && as_len > lat && m_ovl) begin
        m_boot++;
        if (m_boot == M_BOOT) m_ovl = 1'b0;
      end
      bus_cycle($sformatf("rnd%0d", i), addr, rw, lanes, as_len, kind, lat, o_start, m_ovl,
                chg_k, lanes2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
